fifo_rd_stream: RTL and testbench

- Downstream consumer of a standard-mode (non-FWFT) FIFO read port.
- Issues rd_en against empty and captures dout on the FIFO's valid strobe.
- Re-presents the data as a valid/ready stream, sustaining one word per cycle despite the FIFO's read latency.
- Sits in the read-clock domain, directly after the FIFO's read port. Its clk is the FIFO's rd_clk.

---
 rtl/fifo_rd_stream.sv | 107 ++++++++++
 tb/tb_fifo_rd_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a standard-mode (non-FWFT) FIFO read port into a one-word-per-cycle valid/ready stream
// Ports:
//   clk, rst                         FIFO read clock, synchronous active-high reset
//   fifo_empty, fifo_dout, fifo_valid  FIFO read-side status and data
//   fifo_rd_en                       registered FIFO read request
//   flush                            drop buffered and in-flight words
//   m_data, m_valid, m_ready         output stream
//   buf_count                        words held in the local buffer
//   proto_err                        sticky protocol error (cleared only by rst)
// Optional: define FIFO_RD_STREAM_STATS_EN to add saturating word_cnt/stall_cnt outputs.
module fifo_rd_stream #(
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [DATA_W-1:0]            fifo_dout,
    input  logic                         fifo_valid,
    output logic                         fifo_rd_en,
    input  logic                         flush,
    output logic [DATA_W-1:0]            m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         proto_err
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]                  word_cnt,
    output logic [31:0]                  stall_cnt
`endif
);
    localparam int PW  = $clog2(BUF_DEPTH);
    localparam int IFW = $clog2(READ_LATENCY + 1) + 1;
    typedef enum logic {RUN, FLUSH} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [IFW-1:0]    in_flight_q, in_flight_d, grace_q, grace_d;
    logic              rd_en_q, rd_en_d, err_q, err_d;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              pop, full, stale, arrive, push, clr;
    always_comb begin
        pop         = count_q != '0 && m_ready;
        full        = count_q == (PW+1)'(BUF_DEPTH);
        // words requested before reset may still return for READ_LATENCY cycles; drop them quietly
        stale       = grace_q != '0 && in_flight_q == '0;
        arrive      = fifo_valid && state_q == RUN && !stale;
        push        = arrive && (!full || pop);
        clr         = flush || state_q == FLUSH;
        err_d       = err_q || (fifo_valid && in_flight_q == '0 && grace_q == '0) || (arrive && full && !pop);
        in_flight_d = in_flight_q + IFW'(rd_en_q) - IFW'(fifo_valid && in_flight_q != '0);
        grace_d     = grace_q != '0 ? grace_q - IFW'(1) : grace_q;
        wr_ptr_d    = clr ? '0 : (push ? wr_ptr_q + PW'(1) : wr_ptr_q);
        rd_ptr_d    = clr ? '0 : (pop ? rd_ptr_q + PW'(1) : rd_ptr_q);
        count_d     = clr ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        state_d     = state_q == RUN ? (flush ? FLUSH : RUN) : (!flush && in_flight_q == '0 ? RUN : FLUSH);
        // credit check counts words already requested so the buffer can never overrun
        rd_en_d     = state_q == RUN && !fifo_empty && !flush && (32'(count_d) + 32'(in_flight_d) < BUF_DEPTH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            grace_q     <= IFW'(READ_LATENCY);
            rd_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            grace_q     <= grace_d;
            rd_en_q     <= rd_en_d;
            err_q       <= err_d;
        end
        if (push) mem_q[wr_ptr_q] <= fifo_dout;
    end
    assign fifo_rd_en = rd_en_q;
    assign m_valid    = count_q != '0;
    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign buf_count  = count_q;
    assign proto_err  = err_q;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        word_cnt_d  = word_cnt_q + 32'(pop && word_cnt_q != '1);
        stall_cnt_d = stall_cnt_q + 32'(m_valid && !m_ready && stall_cnt_q != '1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized scoreboard bench for fifo_rd_stream against a queue-based FIFO model
module tb_fifo_rd_stream;
    localparam int DW = 8, RL = 1, BD = 4;
    logic clk = 0, rst = 1, fifo_empty = 1, fifo_valid = 0, flush = 0, m_ready = 0, inj = 0;
    logic fifo_rd_en, m_valid, proto_err;
    logic [DW-1:0] fifo_dout = '0, m_data, inj_data = '0;
    logic [$clog2(BD):0] buf_count;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt, stall_cnt;
`endif
    int errors = 0, checks = 0, rd_cnt = 0, hs_cnt = 0, st_cnt = 0;
    logic [DW-1:0] fifo_q[$], exp_q[$];
    logic [DW:0] pipe[$];

    fifo_rd_stream #(.DATA_W(DW), .READ_LATENCY(RL), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .buf_count(buf_count), .proto_err(proto_err)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        m_ready = 1;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            tick;
            n++;
        end
        check(name, fifo_q.size() + exp_q.size(), 0);
    endtask

    // FIFO model: a read pops the queue (and becomes an expected word); data returns RL cycles later.
    // empty reflects words not yet requested, so a registered rd_en never overruns it.
    initial begin
        logic [DW-1:0] w;
        for (int i = 0; i < RL; i++) pipe.push_back('0);
        forever begin
            @(negedge clk);
            #2;
            if (fifo_rd_en === 1'b1 && fifo_q.size() != 0) begin
                w = fifo_q.pop_front();
                exp_q.push_back(w);
                rd_cnt++;
                pipe.push_back({1'b1, w});
            end else begin
                if (fifo_rd_en === 1'b1) check("rd_en_on_empty", 1, 0);
                pipe.push_back('0);
            end
            {fifo_valid, fifo_dout} = pipe.pop_front();
            if (inj) begin
                fifo_valid = 1'b1;
                fifo_dout  = inj_data;
                exp_q.push_back(inj_data);
            end
            fifo_empty = fifo_q.size() == 0;
        end
    end

    // Monitor: compares the presented word with the scoreboard head and retires it on handshake.
    initial forever begin
        @(negedge clk);
        #3;
        if (rst) begin
            hs_cnt = 0;
            st_cnt = 0;
        end else if (m_valid) begin
            if (exp_q.size() == 0) check("unexpected_word", {24'h0, m_data}, 32'hFFFF_FFFF);
            else begin
                check("m_data", m_data, exp_q[0]);
                if (m_ready) void'(exp_q.pop_front());
            end
            if (m_ready) hs_cnt++;
            else st_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, r0, h0;
        tick(2);
        rst = 0;
        check("reset", {m_data, fifo_rd_en, m_valid, proto_err, buf_count}, 0);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("idle", {fifo_rd_en, m_valid, proto_err, buf_count}, 0);
        end
        // three words, ready held high
        m_ready = 1;
        r0 = rd_cnt;
        fifo_q.push_back(8'hFF); fifo_q.push_back(8'hFE); fifo_q.push_back(8'hFD);
        n = 0;
        while (!m_valid && n < 10) begin
            tick;
            n++;
        end
        check("first_word_latency", n, RL + 2);
        for (int i = 1; i < 3; i++) begin
            tick;
            check("back_to_back", m_valid, 1);
        end
        tick(4);
        check("rd_pulses", rd_cnt - r0, 3);
        check("short_drained", exp_q.size(), 0);
        // 20-word burst against a stalled sink
        m_ready = 0;
        r0 = rd_cnt;
        h0 = hs_cnt;
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'(8'hFF - i));
        tick(10);
        check("stall_reads", rd_cnt - r0, BD);
        check("stall_count", buf_count, BD);
        check("stall_head", m_data, 8'hFF);
        drain("burst_drain", 100);
        check("burst_words", hs_cnt - h0, 20);
        check("burst_proto", proto_err, 0);
        // spurious valid strobe
        tick(3);
        inj_data = 8'hA5;
        inj = 1;
        tick;
        inj = 0;
        check("proto_set", proto_err, 1);
        tick(6);
        check("proto_sticky", proto_err, 1);
        check("inj_drained", exp_q.size(), 0);
        rst = 1;
        tick;
        rst = 0;
        exp_q.delete();
        check("proto_rst", proto_err, 0);
        // reset while words are in flight: late returns are dropped without error
        tick(3);
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h40 + i));
        tick(4);
        rst = 1;
        tick;
        rst = 0;
        exp_q.delete();
        drain("grace_drain", 60);
        check("grace_proto", proto_err, 0);
        // flush with a partly filled buffer and one word in flight
        m_ready = 0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'hF4 - i));
        n = 0;
        while (buf_count != 3 && n < 20) begin
            tick;
            n++;
        end
        check("flush_setup", buf_count, 3);
        flush = 1;
        r0 = rd_cnt;
        tick;
        exp_q.delete();
        check("flush_clears", m_valid, 0);
        tick(2);
        flush = 0;
        check("flush_no_rd", rd_cnt - r0, 0);
        n = 0;
        while (!m_valid && n < 20) begin
            tick;
            n++;
        end
        check("after_flush_first", m_data, 8'hF0);
        drain("flush_drain", 60);
        // random traffic with occasional flushes
        for (int i = 0; i < 800; i++) begin
            tick;
            if (flush) begin
                exp_q.delete();
                flush = 0;
            end else if ($urandom_range(0, 59) == 0) flush = 1;
            m_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
        end
        if (flush) begin
            tick;
            exp_q.delete();
            flush = 0;
        end
        drain("random_drain", 400);
        check("random_proto", proto_err, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("word_cnt_model", word_cnt, hs_cnt);
        check("stall_cnt_model", stall_cnt, st_cnt);
        rst = 1;
        tick;
        rst = 0;
        exp_q.delete();
        check("stats_rst", {word_cnt, stall_cnt} == 64'h0, 1);
        tick(3);
        m_ready = 0;
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h10 + i));
        n = 0;
        while (!m_valid && n < 20) begin
            tick;
            n++;
        end
        tick(5);
        m_ready = 1;
        drain("stats_drain", 60);
        check("word_cnt", word_cnt, 16);
        check("stall_cnt", stall_cnt, 5);
`endif
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
